// File: rtl/fir_timer_pkg.sv
// Shared constants and state encoding for the FIR sample-enable timer.
package fir_timer_pkg;

  localparam int unsigned CNT_W_DEF          = 4;
  localparam int unsigned DEFAULT_PERIOD_DEF = 15;
  localparam int unsigned PRESCALE_W_DEF     = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/fir_tick_prescaler.sv
// Tick divider: one tick_c every prescale_in+1 clk cycles while not cleared.
module fir_tick_prescaler #(
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale_in,
  output logic                  tick_c
);

  logic [PRESCALE_W-1:0] pcnt;

  assign tick_c = !clear && (pcnt == prescale_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
    end else if (clear || tick_c) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/fir_sample_timer.sv
// Programmable-period sample-enable timer with start/stop, one-shot mode and
// shadowed period reload. Optional tick prescaler enabled by FST_PRESCALE_EN.
module fir_sample_timer
  import fir_timer_pkg::*;
#(
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned DEFAULT_PERIOD = DEFAULT_PERIOD_DEF,
  parameter int unsigned PRESCALE_W     = PRESCALE_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  oneshot,
  input  logic                  period_load,
  input  logic [CNT_W-1:0]      period_in,
`ifdef FST_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale_in,
`endif
  output logic [CNT_W-1:0]      count,
  output logic                  count_reach,
  output logic                  busy
);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] period_r, period_shadow;
  logic [CNT_W-1:0] count_nxt, period_nxt, shadow_nxt;
  logic             oneshot_r, oneshot_nxt, reach_nxt;
  logic             tick_c, term_c;

`ifdef FST_PRESCALE_EN
  // Held clear outside RUN so every run starts from a fresh prescale phase.
  fir_tick_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk         (clk),
    .reset       (reset),
    .clear       (stop || (state != ST_RUN)),
    .prescale_in (prescale_in),
    .tick_c      (tick_c)
  );
`else
  logic [PRESCALE_W-1:0] unused_prescale;
  assign unused_prescale = '0;
  assign tick_c          = 1'b1;
`endif

  assign term_c = tick_c && (count == period_r);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath decode; a terminal count swaps in the shadow period.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    reach_nxt   = 1'b0;
    period_nxt  = period_r;
    shadow_nxt  = period_shadow;
    oneshot_nxt = oneshot_r;
    case (state)
      ST_IDLE: begin
        count_nxt = '0;
        if (period_load) begin
          period_nxt = period_in;
          shadow_nxt = period_in;
        end
        if (start && !stop) begin
          state_nxt   = ST_RUN;
          oneshot_nxt = oneshot;
        end
      end
      ST_RUN: begin
        if (period_load) begin
          shadow_nxt = period_in;
        end
        if (stop) begin
          state_nxt = ST_IDLE;
          count_nxt = '0;
        end else if (term_c) begin
          count_nxt  = '0;
          reach_nxt  = 1'b1;
          period_nxt = period_shadow;
          if (oneshot_r) begin
            state_nxt = ST_IDLE;
          end
        end else if (tick_c) begin
          count_nxt = count + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count         <= '0;
      count_reach   <= 1'b0;
      busy          <= 1'b0;
      period_r      <= CNT_W'(DEFAULT_PERIOD);
      period_shadow <= CNT_W'(DEFAULT_PERIOD);
      oneshot_r     <= 1'b0;
    end else begin
      count         <= count_nxt;
      count_reach   <= reach_nxt;
      busy          <= (state_nxt == ST_RUN);
      period_r      <= period_nxt;
      period_shadow <= shadow_nxt;
      oneshot_r     <= oneshot_nxt;
    end
  end

endmodule
